// File: rtl/input_state_if.sv
// Player-input bus between the game FSM (master) and the input_state block (slave).
// Carries the start request, raw buttons, expected sequence and the result/feedback outputs.
interface input_state_if;
    logic        en_input;
    logic [3:0]  btn_raw;
    logic [31:0] seq_in_input;
    logic [3:0]  round_ctr;
    logic [1:0]  colour_bus;
    logic        colour_oe;
    logic [3:0]  input_pos;
    logic        complete_input;
    logic        result_pass;
    logic        result_timeout;

    modport master (
        output en_input, btn_raw, seq_in_input, round_ctr,
        input  colour_bus, colour_oe, input_pos, complete_input, result_pass, result_timeout
    );

    modport slave (
        input  en_input, btn_raw, seq_in_input, round_ctr,
        output colour_bus, colour_oe, input_pos, complete_input, result_pass, result_timeout
    );
endinterface

// File: rtl/input_state.sv
// Player-side input block: synchronises and debounces four buttons, checks each
// accepted press against the stored colour sequence and reports pass/fail/timeout.
module input_state #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_n_input,
    input_state_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } state_t;

    logic [3:0]      btn_meta;
    logic [3:0]      btn_sync;
    logic [3:0]      btn_sync_prev;
    logic [3:0]      btn_stable;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_base;

    state_t          state_q, state_d;
    logic [3:0]      pos_q, pos_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic            mismatch_q, mismatch_d;
    logic [1:0]      colour_q, colour_d;
    logic            oe_q, oe_d;
    logic            pass_q, pass_d;
    logic            timeout_q, timeout_d;
    logic            complete_q, complete_d;

    logic            press_valid;
    logic [1:0]      press_colour;
    logic [1:0]      expected_colour;

    // A change in btn_sync restarts the count, so the cycle it changes is the first stable one.
    always_comb begin
        db_base = (btn_sync != btn_sync_prev) ? '0 : db_cnt;
    end

    always_ff @(posedge clk or negedge rst_n_input) begin
        if (!rst_n_input) begin
            btn_meta      <= '0;
            btn_sync      <= '0;
            btn_sync_prev <= '0;
            btn_stable    <= '0;
            db_cnt        <= '0;
        end else begin
            btn_meta      <= bus.btn_raw;
            btn_sync      <= btn_meta;
            btn_sync_prev <= btn_sync;
            if (btn_sync == btn_stable) begin
                db_cnt <= '0;
            end else if (db_base == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_stable <= btn_sync;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_base + 1'b1;
            end
        end
    end

    always_comb begin
        press_valid  = (btn_stable != 4'd0) && ((btn_stable & (btn_stable - 4'd1)) == 4'd0);
        press_colour = 2'd0;
        case (btn_stable)
            4'b0010: press_colour = 2'd1;
            4'b0100: press_colour = 2'd2;
            4'b1000: press_colour = 2'd3;
            default: press_colour = 2'd0;
        endcase
        expected_colour = bus.seq_in_input[{pos_q, 1'b0} +: 2];
    end

    always_ff @(posedge clk or negedge rst_n_input) begin
        if (!rst_n_input) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            tmo_q      <= '0;
            mismatch_q <= 1'b0;
            colour_q   <= '0;
            oe_q       <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            tmo_q      <= tmo_d;
            mismatch_q <= mismatch_d;
            colour_q   <= colour_d;
            oe_q       <= oe_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            complete_q <= complete_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        tmo_d      = tmo_q;
        mismatch_d = mismatch_q;
        colour_d   = colour_q;
        oe_d       = oe_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        complete_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en_input) begin
                    state_d    = ARM;
                    pos_d      = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    mismatch_d = 1'b0;
                end
            end
            ARM: begin
                tmo_d = '0;
                if (btn_stable == 4'd0) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // A press arriving on the final timeout cycle still counts.
                if (press_valid) begin
                    colour_d = press_colour;
                    oe_d     = 1'b1;
                    state_d  = WAIT_RELEASE;
                    if (press_colour != expected_colour) begin
                        mismatch_d = 1'b1;
                    end
                end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    complete_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (btn_stable == 4'd0) begin
                    oe_d = 1'b0;
                    if (mismatch_q) begin
                        pass_d     = 1'b0;
                        complete_d = 1'b1;
                        state_d    = DONE;
                    end else if (pos_q == bus.round_ctr) begin
                        pass_d     = 1'b1;
                        complete_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        pos_d   = pos_q + 4'd1;
                        tmo_d   = '0;
                        state_d = WAIT_PRESS;
                    end
                end
            end
            DONE: begin
                if (!bus.en_input) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.colour_bus     = colour_q;
    assign bus.colour_oe      = oe_q;
    assign bus.input_pos      = pos_q;
    assign bus.complete_input = complete_q;
    assign bus.result_pass    = pass_q;
    assign bus.result_timeout = timeout_q;

endmodule

// File: tb/tb_input_state.sv
// Self-checking bench for input_state: directed scenarios with literal expectations plus
// randomized rounds, all compared every cycle against a sequence-level reference model.
module tb_input_state;

    localparam int DB = 4;
    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst_n_input = 1'b0;

    input_state_if bus();

    input_state #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n_input(rst_n_input),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int dut_pulses  = 0;

    // Reference model: raw-sample history window for the debouncer, round bookkeeping for the game.
    logic [3:0] raw_q[$];
    logic [3:0] m_stable;
    logic [3:0] s_pre;
    bit         m_busy, m_armed, m_holding, m_done, m_bad;
    int         m_wait;
    int         k_idx;
    bit         agree;
    logic [3:0] m_pos;
    logic [1:0] m_colour;
    bit         m_oe, m_pass, m_tmo, m_complete;

    function automatic int onehot_idx(input logic [3:0] b);
        int idx;
        idx = -1;
        if ($countones(b) == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) idx = i;
            end
        end
        return idx;
    endfunction

    function automatic int seq_colour(input logic [31:0] seq, input int k);
        return int'(seq[2*k +: 2]);
    endfunction

    task automatic model_finish();
        m_busy     = 1'b0;
        m_holding  = 1'b0;
        m_done     = 1'b1;
        m_complete = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n_input) begin
        if (!rst_n_input) begin
            raw_q.delete();
            for (int i = 0; i < DB + 1; i++) raw_q.push_back(4'd0);
            m_stable = 4'd0;
            m_busy = 0; m_armed = 0; m_holding = 0; m_done = 0; m_bad = 0;
            m_wait = 0; m_pos = 4'd0; m_colour = 2'd0;
            m_oe = 0; m_pass = 0; m_tmo = 0; m_complete = 0;
        end else begin
            s_pre      = m_stable;
            m_complete = 1'b0;
            if (m_done) begin
                if (!bus.en_input) m_done = 1'b0;
            end else if (!m_busy) begin
                if (bus.en_input) begin
                    m_busy = 1; m_armed = 0; m_holding = 0; m_bad = 0;
                    m_pos = 4'd0; m_pass = 0; m_tmo = 0;
                end
            end else if (!m_armed) begin
                if (s_pre == 4'd0) begin
                    m_armed = 1'b1;
                    m_wait  = 0;
                end
            end else if (!m_holding) begin
                k_idx = onehot_idx(s_pre);
                if (k_idx >= 0) begin
                    m_colour  = k_idx[1:0];
                    m_oe      = 1'b1;
                    m_holding = 1'b1;
                    if (k_idx != seq_colour(bus.seq_in_input, int'(m_pos))) m_bad = 1'b1;
                end else if (m_wait == TO - 1) begin
                    m_tmo  = 1'b1;
                    m_pass = 1'b0;
                    model_finish();
                end else begin
                    m_wait++;
                end
            end else if (s_pre == 4'd0) begin
                m_oe      = 1'b0;
                m_holding = 1'b0;
                if (m_bad) begin
                    m_pass = 1'b0;
                    model_finish();
                end else if (m_pos == bus.round_ctr) begin
                    m_pass = 1'b1;
                    model_finish();
                end else begin
                    m_pos  = m_pos + 4'd1;
                    m_wait = 0;
                end
            end

            // Stable takes a new value once the synchronised input held it for DB cycles.
            raw_q.push_back(bus.btn_raw);
            if (raw_q.size() > DB + 2) void'(raw_q.pop_front());
            agree = 1'b1;
            for (int i = 1; i < DB; i++) begin
                if (raw_q[i] != raw_q[0]) agree = 1'b0;
            end
            if (agree && raw_q[0] != m_stable) m_stable = raw_q[0];
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n_input) begin
                check_output("colour_bus",     int'(bus.colour_bus),     int'(m_colour));
                check_output("colour_oe",      int'(bus.colour_oe),      int'(m_oe));
                check_output("input_pos",      int'(bus.input_pos),      int'(m_pos));
                check_output("complete_input", int'(bus.complete_input), int'(m_complete));
                check_output("result_pass",    int'(bus.result_pass),    int'(m_pass));
                check_output("result_timeout", int'(bus.result_timeout), int'(m_tmo));
                if (bus.complete_input) dut_pulses++;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_round(input logic [3:0] rc, input logic [31:0] seq, input bit hold_en);
        bus.round_ctr    = rc;
        bus.seq_in_input = seq;
        bus.en_input     = 1'b1;
        tick(1);
        if (!hold_en) bus.en_input = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [3:0] btn, input int hold, input int gap);
        bus.btn_raw = btn;
        tick(hold);
        bus.btn_raw = 4'd0;
        tick(gap);
    endtask

    task automatic press_checked(input logic [3:0] btn, input int colour, input int gap);
        bus.btn_raw = btn;
        tick(9);
        check_output("held_oe", int'(bus.colour_oe), 1);
        check_output("held_colour", int'(bus.colour_bus), colour);
        tick(1);
        bus.btn_raw = 4'd0;
        tick(gap);
    endtask

    task automatic hold_check(input logic [3:0] btn, input int n, input string name);
        bus.btn_raw = btn;
        repeat (n) begin
            tick(1);
            check_output(name, int'(bus.colour_oe), 0);
        end
    endtask

    task automatic wait_complete(input int budget, output int n);
        int p;
        p = dut_pulses;
        n = 0;
        while (dut_pulses == p && n < budget) begin
            tick(1);
            n++;
        end
        check_output("complete_seen", dut_pulses - p, 1);
    endtask

    task automatic full_round();
        int n;
        int p0;
        logic [3:0] b;
        p0 = dut_pulses;
        start_round(4'd3, 32'h0000_00E4, 1'b0);
        for (int c = 0; c < 4; c++) begin
            b = 4'b0001 << c;
            press_checked(b, c, (c == 3) ? 0 : 10);
        end
        wait_complete(30, n);
        tick(5);
        check_output("full_pass", int'(bus.result_pass), 1);
        check_output("full_timeout", int'(bus.result_timeout), 0);
        check_output("full_pos", int'(bus.input_pos), 3);
        check_output("full_pulses", dut_pulses - p0, 1);
    endtask

    initial begin
        int n;
        int p;
        int act;
        int col;
        logic [3:0] rc;
        logic [3:0] btn;
        logic [31:0] seq;
        bit hold_en;
        bit reset_hit;

        bus.en_input     = 1'b0;
        bus.btn_raw      = 4'd0;
        bus.seq_in_input = 32'd0;
        bus.round_ctr    = 4'd0;
        fork
            compare_loop();
        join_none

        tick(3);
        check_output("reset_colour_bus", int'(bus.colour_bus), 0);
        check_output("reset_oe", int'(bus.colour_oe), 0);
        check_output("reset_pos", int'(bus.input_pos), 0);
        check_output("reset_complete", int'(bus.complete_input), 0);
        check_output("reset_pass", int'(bus.result_pass), 0);
        check_output("reset_timeout", int'(bus.result_timeout), 0);
        rst_n_input = 1'b1;
        tick(2);

        full_round();
        tick(5);

        // Second colour is wrong: fails on its release with the position left at 1.
        start_round(4'd3, 32'h0000_00E4, 1'b0);
        apply_stimulus(4'b0001, 10, 10);
        apply_stimulus(4'b0100, 10, 0);
        wait_complete(30, n);
        tick(3);
        check_output("mismatch_pass", int'(bus.result_pass), 0);
        check_output("mismatch_timeout", int'(bus.result_timeout), 0);
        check_output("mismatch_pos", int'(bus.input_pos), 1);
        tick(5);

        start_round(4'd0, 32'h0000_00E4, 1'b0);
        wait_complete(TO + 60, n);
        check_output("timeout_latency", n, TO + 1);
        check_output("timeout_flag", int'(bus.result_timeout), 1);
        check_output("timeout_pass", int'(bus.result_pass), 0);
        tick(5);

        start_round(4'd0, 32'h0000_0001, 1'b0);
        hold_check(4'b0011, 15, "dual_button_oe");
        hold_check(4'b0000, 10, "dual_release_oe");
        repeat (5) begin
            hold_check(4'b0010, 2, "chatter_oe");
            hold_check(4'b0000, 2, "chatter_oe");
        end
        bus.btn_raw = 4'b0010;
        tick(6);
        check_output("chatter_oe_early", int'(bus.colour_oe), 0);
        tick(1);
        check_output("chatter_oe_accept", int'(bus.colour_oe), 1);
        check_output("chatter_colour", int'(bus.colour_bus), 1);
        tick(3);
        bus.btn_raw = 4'd0;
        wait_complete(30, n);
        check_output("chatter_pass", int'(bus.result_pass), 1);
        tick(5);

        bus.btn_raw = 4'b0001;
        tick(10);
        start_round(4'd0, 32'h0000_0000, 1'b1);
        hold_check(4'b0001, 15, "held_start_oe");
        hold_check(4'b0000, 10, "held_release_oe");
        press_checked(4'b0001, 0, 0);
        wait_complete(30, n);
        check_output("held_pass", int'(bus.result_pass), 1);
        p = dut_pulses;
        tick(20);
        check_output("held_en_no_restart", dut_pulses - p, 0);
        check_output("held_en_pass_kept", int'(bus.result_pass), 1);
        bus.en_input = 1'b0;
        tick(3);
        bus.en_input = 1'b1;
        tick(3);
        check_output("restart_pass_cleared", int'(bus.result_pass), 0);
        bus.en_input = 1'b0;
        apply_stimulus(4'b0001, 10, 0);
        wait_complete(30, n);
        check_output("restart_pass", int'(bus.result_pass), 1);
        tick(5);

        // Reset while a button is held: outputs drop at once and no done pulse follows.
        start_round(4'd3, 32'h0000_00E4, 1'b0);
        bus.btn_raw = 4'b0001;
        tick(9);
        check_output("pre_reset_oe", int'(bus.colour_oe), 1);
        p = dut_pulses;
        rst_n_input = 1'b0;
        #1;
        check_output("rst_colour_bus", int'(bus.colour_bus), 0);
        check_output("rst_oe", int'(bus.colour_oe), 0);
        check_output("rst_pos", int'(bus.input_pos), 0);
        check_output("rst_complete", int'(bus.complete_input), 0);
        check_output("rst_pass", int'(bus.result_pass), 0);
        check_output("rst_timeout", int'(bus.result_timeout), 0);
        bus.btn_raw = 4'd0;
        tick(3);
        rst_n_input = 1'b1;
        tick(20);
        check_output("rst_no_pulse", dut_pulses - p, 0);
        full_round();
        tick(5);

        for (int r = 0; r < 30; r++) begin
            rc        = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            seq       = $urandom;
            hold_en   = 1'($urandom_range(0, 1));
            reset_hit = 1'b0;
            start_round(rc, seq, hold_en);
            for (int g = 0; g < 40 && m_busy && !reset_hit; g++) begin
                act = $urandom_range(0, 99);
                if (act < 4) begin
                    tick(TO + 20);
                end else begin
                    if (act < 12) begin
                        repeat ($urandom_range(2, 4)) begin
                            bus.btn_raw = 4'($urandom_range(0, 15));
                            tick($urandom_range(1, 2));
                        end
                        bus.btn_raw = 4'd0;
                        tick(2);
                    end
                    col = (act < 85) ? seq_colour(seq, int'(m_pos)) : $urandom_range(0, 3);
                    btn = 4'b0001 << col;
                    if (act >= 95) btn = btn | 4'($urandom_range(0, 15));
                    apply_stimulus(btn, $urandom_range(7, 14), $urandom_range(7, 12));
                end
                if ($urandom_range(0, 49) == 0) begin
                    bus.en_input = 1'b0;
                    rst_n_input  = 1'b0;
                    bus.btn_raw  = 4'd0;
                    tick(2);
                    rst_n_input  = 1'b1;
                    reset_hit    = 1'b1;
                end
            end
            tick(10);
            bus.en_input = 1'b0;
            tick($urandom_range(1, 5));
        end

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_state.md
Name: input_state

Overview:
- Player-side counterpart of the colour display block. Captures button presses from four raw push-buttons and debounces them.
- Compares each accepted press against the stored colour sequence. Expects (round_ctr + 1) colours.
- Reports pass, fail or timeout to the top-level game FSM with a 1-cycle done pulse.
- Echoes the pressed colour on a colour bus for LED feedback.

Parameters:
- DEBOUNCE_CYCLES, 50_000: consecutive stable cycles needed before a button change is accepted (5 ms at 10 MHz).
- TIMEOUT_CYCLES, 50_000_000: maximum cycles allowed waiting for each press (5 s at 10 MHz).

Ports:
- clk  in  1  system clock
- rst_n_input  in  1  reset, asynchronous, active-low
- en_input  in  1  level start request from the game FSM
- btn_raw  in  4  asynchronous active-high buttons; bit i = colour i
- seq_in_input  in  32  16 colours packed LSB-first; colour k = bits [2k+1:2k]
- round_ctr  in  4  N means N+1 colours are expected
- colour_bus  out  2  colour of the currently held accepted press
- colour_oe  out  1  1 = colour_bus valid (button held)
- input_pos  out  4  index of the next colour expected
- complete_input  out  1  1-cycle done pulse
- result_pass  out  1  1 = all colours matched; held until next start
- result_timeout  out  1  1 = failure caused by timeout; held until next start

Behaviour:
- Reset (rst_n_input low, async): every output 0, FSM to IDLE, all counters 0, synchronisers 0, btn_stable 0.
- Input conditioning:
  - btn_raw passes through a 2-flop synchroniser, giving btn_sync.
  - Debounce counter resets whenever btn_sync == btn_stable or btn_sync changes.
  - btn_stable <= btn_sync once btn_sync has differed from btn_stable for DEBOUNCE_CYCLES consecutive cycles.
  - Latency from raw edge to btn_stable = 2 + DEBOUNCE_CYCLES cycles.
- A valid press is btn_stable exactly one-hot. Pressed colour = index of the set bit (0..3). Zero or multiple bits set is not a press.
- FSM states: IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE:
  - On en_input = 1, go to ARM.
  - On that transition: input_pos <= 0, result_pass <= 0, result_timeout <= 0, mismatch flag cleared.
- ARM:
  - Wait for btn_stable == 0, so buttons held at start are ignored, then go to WAIT_PRESS.
  - Timeout counter cleared.
- WAIT_PRESS:
  - Timeout counter increments each cycle.
  - Valid press seen: latch colour to colour_bus, colour_oe <= 1. Set mismatch if colour != seq_in_input[2*input_pos +: 2]. Go to WAIT_RELEASE.
  - Counter reaches TIMEOUT_CYCLES-1 with no valid press: result_timeout <= 1, result_pass <= 0, go to DONE.
  - Press and timeout in the same cycle: the press wins.
- WAIT_RELEASE:
  - colour_oe stays 1 while btn_stable != 0. Extra buttons pressed meanwhile are ignored. No timeout in this state.
  - On btn_stable == 0, colour_oe <= 0, then:
    - mismatch set: result_pass <= 0, go to DONE.
    - input_pos == round_ctr: result_pass <= 1, go to DONE.
    - otherwise: input_pos <= input_pos + 1, timeout counter cleared, go to WAIT_PRESS.
- DONE:
  - complete_input = 1 for exactly the cycle after entry; 0 otherwise.
  - Results hold.
  - Return to IDLE only when en_input = 0, so a held en_input never restarts the block.
- en_input falling mid-round has no effect. The round completes normally.
- round_ctr and seq_in_input are sampled live and must stay stable during a round.
- input_pos is 4 bits. round_ctr = 15 gives 16 colours with no wrap; input_pos never exceeds round_ctr.
- Async reset mid-round returns to the reset state immediately with no complete_input pulse.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=200):
- Full correct round: seq_in_input=32'h0000_00E4 (colours 0,1,2,3), round_ctr=3, en_input pulse, clean presses btn 0001, 0010, 0100, 1000, each held 10 cycles. Required: colour_bus echoes 0,1,2,3 with colour_oe high while held. One complete_input pulse after the last release. result_pass=1, result_timeout=0, input_pos=3.
- Mismatch: same seq, round_ctr=3, press btn 0001 then 0100. Required: complete_input after the second release. result_pass=0, result_timeout=0, input_pos=1.
- Timeout: round_ctr=0, start, no presses. Required: complete_input 200 cycles after entering WAIT_PRESS. result_timeout=1, result_pass=0.
- Debounce and chatter: btn_raw 0010 toggling every 2 cycles for 20 cycles, then stable. Required: exactly one accepted press, 2+4 cycles after stability. Two simultaneous buttons (0011) are never accepted.
- Held at start / held enable: btn 0001 held when en_input rises. Required: no press until it is released and pressed again. en_input kept high after completion: no second round until en_input goes low then high.
- Reset mid-round: assert rst_n_input during WAIT_RELEASE. Required: all outputs 0 immediately, no complete_input pulse. A fresh round after reset behaves as in the first scenario.
